// File: rtl/vector_gather_pkg.sv
// Shared defines for the embedding datapath plus typed mirrors for SV users.
// Holds the three sizing knobs consumed by vector_gather:
//   MAX_EMBEDDING_DIM - elements per assembled embedding vector
//   INTEGER_WIDTH     - base integer width (elements are twice this wide)
//   GATHER_CHUNK_LEN  - elements delivered per upstream beat
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 16
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif
`ifndef GATHER_CHUNK_LEN
`define GATHER_CHUNK_LEN 4
`endif

package vector_gather_pkg;
  localparam int unsigned MAX_EMBEDDING_DIM = `MAX_EMBEDDING_DIM;
  localparam int unsigned INTEGER_WIDTH     = `INTEGER_WIDTH;
  localparam int unsigned GATHER_CHUNK_LEN  = `GATHER_CHUNK_LEN;
endpackage

// File: rtl/vector_gather.sv
// Gathers CHUNK_LEN-element beats into one OUTPUT_LEN-element vector and
// hands it downstream through a registered output stage. A short vector is
// closed early with last_in and zero-filled above the final chunk.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   vld_in/rdy_out- upstream beat handshake (rdy_out combinational)
//   chunk_in      - beat payload, element 0 lands at the lowest index
//   last_in       - final beat of a (possibly short) vector
//   vld_out/rdy_in- downstream vector handshake
//   list_out      - assembled vector, straight from the output register
module vector_gather
  import vector_gather_pkg::*;
#(
  parameter int unsigned OUTPUT_LEN = MAX_EMBEDDING_DIM,
  parameter int unsigned W          = 2 * INTEGER_WIDTH,
  parameter int unsigned CHUNK_LEN  = GATHER_CHUNK_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld_in,
  output logic                rdy_out,
  input  logic signed [W-1:0] chunk_in [CHUNK_LEN],
  input  logic                last_in,
  output logic                vld_out,
  input  logic                rdy_in,
  output logic signed [W-1:0] list_out [OUTPUT_LEN]
);

  localparam int unsigned NUM_BEATS = OUTPUT_LEN / CHUNK_LEN;
  localparam int unsigned CW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BEATS - 1);

  logic [CW-1:0]       beat_cnt;
  logic                asm_full;
  logic signed [W-1:0] asm_buf [OUTPUT_LEN];
  logic                accept;
  logic                transfer;
  logic                final_beat;

  // Only a full assembly buffer behind a stalled output blocks upstream.
  assign rdy_out    = !asm_full || !vld_out || rdy_in;
  assign transfer   = asm_full && (!vld_out || rdy_in);
  assign accept     = vld_in && rdy_out;
  assign final_beat = last_in || (beat_cnt == LAST_BEAT);

  // Beat counter, assembly-full flag and output valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      asm_full <= 1'b0;
      vld_out  <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt <= final_beat ? '0 : beat_cnt + CW'(1);
      end
      // A closing beat can only be accepted while full if the buffer is
      // being emptied in the same cycle, so setting wins over clearing.
      if (accept && final_beat) begin
        asm_full <= 1'b1;
      end else if (transfer) begin
        asm_full <= 1'b0;
      end
      if (transfer) begin
        vld_out <= 1'b1;
      end else if (rdy_in) begin
        vld_out <= 1'b0;
      end
    end
  end

  // Assembly buffer write / zero-fill and output register load. The output
  // register samples asm_buf before this cycle's beat lands in it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < OUTPUT_LEN; i++) begin
        asm_buf[i]  <= '0;
        list_out[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < OUTPUT_LEN; i++) begin
        if (accept) begin
          if (CW'(i / CHUNK_LEN) == beat_cnt) begin
            asm_buf[i] <= chunk_in[i % CHUNK_LEN];
          end else if (last_in && (CW'(i / CHUNK_LEN) > beat_cnt)) begin
            asm_buf[i] <= '0;
          end
        end
        if (transfer) begin
          list_out[i] <= asm_buf[i];
        end
      end
    end
  end

  // A vector must never close while the assembly buffer still holds one.
  a_no_overrun : assert property (
    @(posedge clk) disable iff (!rst)
    (vld_in && rdy_out && asm_full) |-> transfer
  );

endmodule

// File: tb/tb_vector_gather.sv
// Self-checking bench for vector_gather (OUTPUT_LEN=16, CHUNK_LEN=4, W=16).
// A queue-based reference model tracks completed vectors awaiting delivery.
`timescale 1ns/1ps
module tb_vector_gather;
  localparam int OL = 16;
  localparam int CL = 4;
  localparam int W  = 16;

  typedef logic signed [W-1:0] vec_t [OL];
  typedef struct {
    logic vld;
    logic last;
    logic rdy;
    int   base;
    int   step;
    logic exp_vld;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vld_in = 1'b0;
  logic last_in = 1'b0;
  logic rdy_in = 1'b0;
  logic signed [W-1:0] chunk_in [CL];
  logic vld_out;
  logic rdy_out;
  logic signed [W-1:0] list_out [OL];

  vector_gather #(.OUTPUT_LEN(OL), .W(W), .CHUNK_LEN(CL)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
    .chunk_in(chunk_in), .last_in(last_in), .vld_out(vld_out),
    .rdy_in(rdy_in), .list_out(list_out)
  );

  always #5 clk = ~clk;

  // Model state: completed vectors not yet taken downstream, plus the one
  // under construction.
  vec_t exp_q[$];
  vec_t cur;
  int   cur_pos;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_taken = 0;
  int   take_cyc[$];

  logic s_vld, s_rdy, s_acc, s_take;
  vec_t s_list;
  vec_t zv;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    int bad;
    bad = -1;
    n_cmp++;
    for (int k = OL - 1; k >= 0; k--) if (act[k] !== exp[k]) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: element %0d got %0d expected %0d (cycle %0d)",
               name, bad, act[bad], exp[bad], cyc);
    end
  endtask

  task automatic drive(input logic v, input logic l, input int base, input int step);
    vld_in  = v;
    last_in = l;
    for (int k = 0; k < CL; k++) chunk_in[k] = W'(base + step * k);
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_pos = 0;
    for (int k = 0; k < OL; k++) cur[k] = '0;
  endtask

  // Sample on the falling edge, check against the model, update the model
  // with this cycle's handshakes, then step past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    s_vld  = vld_out;
    s_rdy  = rdy_out;
    s_list = list_out;
    s_acc  = vld_in && rdy_out;
    s_take = vld_out && rdy_in;
    // Upstream may only stall when two finished vectors are held and the
    // downstream is not taking one.
    chk("rdy_out", s_rdy, (exp_q.size() < 2) || rdy_in);
    if (s_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL vld_out_spurious: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        chk_vec("list_out", s_list, exp_q[0]);
      end
    end
    if (s_take && exp_q.size() > 0) begin
      exp_q.delete(0);
      n_taken++;
      take_cyc.push_back(cyc);
    end
    if (s_acc) begin
      for (int k = 0; k < CL; k++) cur[cur_pos * CL + k] = chunk_in[k];
      if (last_in || cur_pos == OL / CL - 1) begin
        for (int k = (cur_pos + 1) * CL; k < OL; k++) cur[k] = '0;
        exp_q.push_back(cur);
        cur_pos = 0;
      end else begin
        cur_pos++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic row_t mk(input logic v, input logic l, input int base,
                              input int step, input logic ev);
    row_t r;
    r.vld = v; r.last = l; r.rdy = 1'b1; r.base = base; r.step = step; r.exp_vld = ev;
    return r;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    row_t tbl [19];
    int j;
    int guard;
    int base_taken;
    int gap_ok;
    int miss;
    int rdy_bias;
    logic seen;

    for (int k = 0; k < OL; k++) zv[k] = '0;
    drive(1'b0, 1'b0, 0, 0);
    rdy_in = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vld_out", vld_out, 0);
    chk("reset_rdy_out", rdy_out, 1);
    chk_vec("reset_list_out", list_out, zv);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Full vector 1..16, short vector with last_in, then restart at index 0
    tbl[0]  = mk(1, 0,  1,  1, 0);
    tbl[1]  = mk(1, 0,  5,  1, 0);
    tbl[2]  = mk(1, 0,  9,  1, 0);
    tbl[3]  = mk(1, 0, 13,  1, 0);
    tbl[4]  = mk(0, 0,  0,  0, 0);
    tbl[5]  = mk(0, 0,  0,  0, 1);
    tbl[6]  = mk(0, 0,  0,  0, 0);
    tbl[7]  = mk(1, 0, -1, -1, 0);
    tbl[8]  = mk(1, 1,  5,  1, 0);
    tbl[9]  = mk(0, 0,  0,  0, 0);
    tbl[10] = mk(0, 0,  0,  0, 1);
    tbl[11] = mk(0, 0,  0,  0, 0);
    tbl[12] = mk(1, 0, 21,  1, 0);
    tbl[13] = mk(1, 0, 25,  1, 0);
    tbl[14] = mk(1, 0, 29,  1, 0);
    tbl[15] = mk(1, 0, 33,  1, 0);
    tbl[16] = mk(0, 0,  0,  0, 0);
    tbl[17] = mk(0, 0,  0,  0, 1);
    tbl[18] = mk(0, 0,  0,  0, 0);
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].vld, tbl[i].last, tbl[i].base, tbl[i].step);
      rdy_in = tbl[i].rdy;
      cycle();
      chk($sformatf("tbl%0d_vld_out", i), s_vld, tbl[i].exp_vld);
      if (i == 5) begin
        chk("full_first", s_list[0], 1);
        chk("full_last", s_list[15], 16);
      end
      if (i == 10) begin
        chk("short_first", s_list[0], -1);
        chk("short_elem7", s_list[7], 8);
        chk("short_zero8", s_list[8], 0);
        chk("short_zero15", s_list[15], 0);
      end
      if (i == 17) chk("restart_idx0", s_list[0], 21);
    end

    // Downstream stalled while three vectors are offered back to back
    rdy_in = 1'b0;
    base_taken = n_taken;
    j = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b0, 200 + 4 * j, 1);
      cycle();
      if (s_acc) j++;
    end
    chk("stall_beats_accepted", j, 8);
    chk("stall_rdy_out", s_rdy, 0);
    chk("stall_vld_out", s_vld, 1);
    chk("stall_hold_A", s_list[0], 200);
    rdy_in = 1'b1;
    guard = 0;
    while (j < 12 && guard < 40) begin
      drive(1'b1, 1'b0, 200 + 4 * j, 1);
      cycle();
      if (s_acc) j++;
      guard++;
    end
    drive(1'b0, 1'b0, 0, 0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("stall_all_beats", j, 12);
    chk("stall_drained", exp_q.size(), 0);
    chk("stall_delivered", n_taken - base_taken, 3);
    cycle();

    // Continuous streaming, 8 vectors
    take_cyc.delete();
    miss = 0;
    for (int b = 0; b < 32; b++) begin
      drive(1'b1, 1'b0, 1000 + 4 * b, 1);
      cycle();
      if (!s_acc) miss++;
    end
    drive(1'b0, 1'b0, 0, 0);
    repeat (4) cycle();
    chk("stream_no_bubble", miss, 0);
    chk("stream_vectors", take_cyc.size(), 8);
    gap_ok = 1;
    for (int k = 1; k < take_cyc.size(); k++)
      if (take_cyc[k] - take_cyc[k-1] != 4) gap_ok = 0;
    chk("stream_pulse_every_4", gap_ok, 1);

    // Reset mid-vector
    drive(1'b1, 1'b0, 500, 1);
    cycle();
    drive(1'b1, 1'b0, 504, 1);
    cycle();
    drive(1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    #1;
    chk("midrst_vld_out", vld_out, 0);
    chk("midrst_rdy_out", rdy_out, 1);
    chk_vec("midrst_list_out", list_out, zv);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("postrst_rdy_out", rdy_out, 1);
    @(posedge clk);
    #1;
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 1'b0, 100 + 4 * b, 1);
      cycle();
    end
    drive(1'b0, 1'b0, 0, 0);
    seen = 1'b0;
    guard = 0;
    while (!seen && guard < 10) begin
      cycle();
      if (s_vld) begin
        seen = 1'b1;
        chk("postrst_first", s_list[0], 100);
        chk("postrst_last", s_list[15], 115);
      end
      guard++;
    end
    chk("postrst_seen", seen, 1);
    cycle();

    // Random traffic against the model
    rdy_bias = 3;
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) rdy_bias = $urandom_range(1, 4);
      rdy_in  = ($urandom_range(0, 4) < rdy_bias);
      vld_in  = ($urandom_range(0, 3) != 0);
      last_in = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < CL; k++) chunk_in[k] = W'($urandom);
      cycle();
    end
    drive(1'b0, 1'b0, 0, 0);
    rdy_in = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      cycle();
      guard++;
    end
    chk("random_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_gather.md
VECTOR_GATHER -- requirements
Module: vector_gather

Interface
REQ-001 SHALL have parameter OUTPUT_LEN, default `MAX_EMBEDDING_DIM, meaning elements per assembled vector.
REQ-002 SHALL have parameter W, default 2*`INTEGER_WIDTH, meaning signed element width.
REQ-003 SHALL have parameter CHUNK_LEN, default `GATHER_CHUNK_LEN, meaning elements accepted per input beat; OUTPUT_LEN divisible by CHUNK_LEN, both powers of two.
REQ-004 SHALL have derived localparam NUM_BEATS = OUTPUT_LEN/CHUNK_LEN, counter width max(1,$clog2(NUM_BEATS)).
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port vld_in, input, 1, upstream beat valid.
REQ-008 SHALL have port rdy_out, output, 1, ready to upstream.
REQ-009 SHALL have port chunk_in, input, signed [W-1:0] x CHUNK_LEN, beat payload.
REQ-010 SHALL have port last_in, input, 1, marks final beat of a (possibly short) vector.
REQ-011 SHALL have port vld_out, output, 1, assembled vector valid.
REQ-012 SHALL have port rdy_in, input, 1, downstream ready.
REQ-013 SHALL have port list_out, output, signed [W-1:0] x OUTPUT_LEN, assembled vector from the output register.

Function
REQ-014 SHALL accept a beat when vld_in && rdy_out, writing chunk_in to elements [beat_cnt*CHUNK_LEN +: CHUNK_LEN] of the assembly buffer, with chunk_in element 0 at the lowest index.
REQ-015 SHALL increment beat_cnt on each accepted beat and wrap it to 0 and set asm_full on an accepted beat with beat_cnt==NUM_BEATS-1 or last_in==1.
REQ-016 SHALL, on early last_in (beat_cnt<NUM_BEATS-1), zero-fill all assembly elements above the accepted chunk in the same cycle.
REQ-017 SHALL define transfer = asm_full && (!vld_out || rdy_in); on transfer, the output register loads the assembly buffer, vld_out is set and asm_full is cleared.
REQ-018 SHALL clear vld_out when vld_out && rdy_in && !transfer.
REQ-019 SHALL drive rdy_out = !asm_full || !vld_out || rdy_in (combinational from rdy_in permitted).
REQ-020 SHALL, when a beat is accepted in the same cycle as transfer, write it into the freshly emptied assembly buffer with the output register capturing the pre-write contents.
REQ-021 SHALL have latency: final beat accepted in cycle t gives vld_out high from cycle t+2 if downstream is unstalled.
REQ-022 SHALL sustain one vector per NUM_BEATS cycles under continuous vld_in/rdy_in, with no bubbles.
REQ-023 SHALL hold list_out stable while vld_out && !rdy_in, and ignore chunk_in/last_in while vld_in==0.
REQ-024 SHALL, when a vector's final beat is accepted while asm_full, be unreachable; rdy_out==0 guarantees it, and an assertion SHALL check it.

Reset
REQ-025 SHALL, with rst low (asynchronously), clear beat_cnt, asm_full, vld_out, the assembly buffer and the output register to 0, so list_out reads all zeros.
REQ-026 SHALL discard a partially assembled or pending vector on reset mid-operation; the first post-reset beat lands at elements [0 +: CHUNK_LEN].
REQ-027 SHALL have rdy_out==1 during and immediately after reset.

Structure
REQ-028 SHALL have `GATHER_CHUNK_LEN defined alongside `MAX_EMBEDDING_DIM and `INTEGER_WIDTH in the shared defines package; no new typedefs.
REQ-029 SHALL be a single module with no sub-modules; its output feeds list_in of the tree-reduction pipeline stage directly.

Verification (OUTPUT_LEN=16, CHUNK_LEN=4, W=16)
REQ-030 SHALL cover: 4 beats of values 1..16, rdy_in=1 -> vld_out high two cycles after beat 4, list_out=[1..16], then vld_out low.
REQ-031 SHALL cover: 2 beats {-1,-2,-3,-4},{5,6,7,8} with last_in on beat 2 -> list_out=[-1..-4,5..8,0x8], next vector starting at index 0.
REQ-032 SHALL cover: rdy_in=0, three full vectors offered back-to-back -> vector A held stable, vector B in assembly, rdy_out=0 after B's 4th beat; rdy_in=1 drains A,B,C in order with no loss or duplication.
REQ-033 SHALL cover: continuous vld_in/rdy_in for 8 vectors -> rdy_out never low, vld_out pulses every 4 cycles, data correct.
REQ-034 SHALL cover: rst low after 2 beats of a vector -> all outputs 0; post-reset 4 beats of 100..115 -> list_out=[100..115].
REQ-035 SHALL cover: random vld_in/rdy_in/last_in for 10k cycles against a scoreboard model -> all vectors match and the REQ-024 assertion never fires.
